// File: rtl/data_pack_pkg.sv
// Shared definitions for the softmax-path pack/unpack blocks.
// Holds width defaults, beat counts and the unpacker state type.
package data_pack_pkg;

    localparam int DEF_IN_W   = 128;
    localparam int DEF_OUT_W  = 16;
    localparam int WORD_BEATS = 8;
    localparam int BYTE_BEATS = 16;
    localparam int CNT_W      = 4;

    typedef enum logic {
        UP_IDLE,
        UP_SEND
    } unpack_state_t;

    // Index of the final beat for a word of the given unpack mode.
    function automatic logic [CNT_W-1:0] last_beat_idx(input logic mode);
        return mode ? CNT_W'(BYTE_BEATS - 1) : CNT_W'(WORD_BEATS - 1);
    endfunction

endpackage

// File: rtl/unpack_beat_sel.sv
// Combinational beat selector: picks a 16-bit slice or a zero-extended
// byte out of a wide word, LSB first.
module unpack_beat_sel
    import data_pack_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  data,
    input  logic             mode,
    input  logic [CNT_W-1:0] idx,
    output logic [OUT_W-1:0] beat
);

    localparam int BYTE_W = OUT_W / 2;

    logic [OUT_W-1:0] word_slices [WORD_BEATS];
    logic [OUT_W-1:0] byte_slices [BYTE_BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BEATS; gi++) begin : g_word
            assign word_slices[gi] = data[gi*OUT_W +: OUT_W];
        end
        for (gi = 0; gi < BYTE_BEATS; gi++) begin : g_byte
            assign byte_slices[gi] = {{(OUT_W-BYTE_W){1'b0}}, data[gi*BYTE_W +: BYTE_W]};
        end
    endgenerate

    assign beat = mode ? byte_slices[idx] : word_slices[idx[2:0]];

endmodule

// File: rtl/data_unpacker.sv
// Serialises 128-bit words into 16-bit FIFO writes (8 slices or 16
// zero-extended bytes), with a one-word skid buffer on the input side.
module data_unpacker
    import data_pack_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_mode,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             full,
    output logic             wr_en,
    output logic [OUT_W-1:0] data_out,
    output logic             pkt_done,
    output logic             busy
);

    unpack_state_t    state_reg;
    logic [IN_W-1:0]  cur_data_reg;
    logic             cur_mode_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IN_W-1:0]  nxt_data_reg;
    logic             nxt_mode_reg;
    logic             nxt_valid_reg;

    logic             wr_en_reg;
    logic             pkt_done_reg;
    logic [OUT_W-1:0] data_out_reg;

    logic [OUT_W-1:0] beat;
    logic             accept;
    logic             issue;
    logic             last_issue;

    unpack_beat_sel #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_beat_sel (
        .data (cur_data_reg),
        .mode (cur_mode_reg),
        .idx  (cnt_reg),
        .beat (beat)
    );

    assign in_ready   = !nxt_valid_reg;
    assign accept     = in_valid && in_ready;
    // Issuing only when the previous edge did not write leaves a cycle for
    // the FIFO's full flag to catch up, so a late full never overflows it.
    assign issue      = (state_reg == UP_SEND) && !full && !wr_en_reg;
    assign last_issue = issue && (cnt_reg == last_beat_idx(cur_mode_reg));
    assign busy       = (state_reg == UP_SEND) || nxt_valid_reg;

    assign wr_en    = wr_en_reg;
    assign data_out = data_out_reg;
    assign pkt_done = pkt_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= UP_IDLE;
            cur_data_reg  <= '0;
            cur_mode_reg  <= 1'b0;
            cnt_reg       <= '0;
            nxt_data_reg  <= '0;
            nxt_mode_reg  <= 1'b0;
            nxt_valid_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            pkt_done_reg  <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            wr_en_reg    <= issue;
            pkt_done_reg <= last_issue;
            if (issue) begin
                data_out_reg <= beat;
                cnt_reg      <= cnt_reg + 1'b1;
            end

            case (state_reg)
                UP_IDLE: begin
                    if (accept) begin
                        cur_data_reg <= in_data;
                        cur_mode_reg <= byte_mode;
                        cnt_reg      <= '0;
                        state_reg    <= UP_SEND;
                    end
                end
                UP_SEND: begin
                    if (last_issue) begin
                        cnt_reg <= '0;
                        // A buffered word always wins; in_ready is low then,
                        // so no new word can be accepted on this edge.
                        if (nxt_valid_reg) begin
                            cur_data_reg  <= nxt_data_reg;
                            cur_mode_reg  <= nxt_mode_reg;
                            nxt_valid_reg <= 1'b0;
                        end else if (accept) begin
                            cur_data_reg <= in_data;
                            cur_mode_reg <= byte_mode;
                        end else begin
                            state_reg <= UP_IDLE;
                        end
                    end else if (accept) begin
                        nxt_data_reg  <= in_data;
                        nxt_mode_reg  <= byte_mode;
                        nxt_valid_reg <= 1'b1;
                    end
                end
                default: state_reg <= UP_IDLE;
            endcase
        end
    end

endmodule
